// File: rtl/pipelined_carry_increment_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-increment adder.
// slave = adder side, master = producer/consumer side.
interface pipelined_carry_increment_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf
   );

   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf
   );
endinterface

// File: rtl/pipelined_carry_increment_adder.sv
// Pipelined carry-increment add/sub: LAT=WIDTH/BLK/STAGE_BLKS cycles, one beat per cycle.
// All stages advance together when the output slot is empty or accepted; otherwise everything holds.
module pipelined_carry_increment_adder #(
   parameter int WIDTH      = 32,
   parameter int BLK        = 4,
   parameter int STAGE_BLKS = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   pipelined_carry_increment_adder_if.slave bus
);
   localparam int NBLK = WIDTH / BLK;
   localparam int LAT  = NBLK / STAGE_BLKS;

   logic             w_adv;
   logic [WIDTH-1:0] w_src_a [LAT];
   logic [WIDTH-1:0] w_src_b [LAT];
   logic [WIDTH-1:0] w_src_s [LAT];
   logic             w_src_c [LAT];
   logic [WIDTH-1:0] w_nx_s  [LAT];
   logic             w_nx_c  [LAT];
   logic             w_ovf;

   logic             r_v [LAT];
   logic [WIDTH-1:0] r_s [LAT];
   logic             r_c [LAT];
   logic             r_ovf;

   assign w_adv        = !r_v[LAT-1] || bus.out_ready;
   assign bus.in_ready = w_adv;

   // Subtraction folds into addition: invert B once here and force the carry-in.
   assign w_src_a[0] = bus.in_a;
   assign w_src_b[0] = bus.in_b ^ {WIDTH{bus.in_sub}};
   assign w_src_s[0] = '0;
   assign w_src_c[0] = bus.in_sub | bus.in_cin;

   generate
      for (genvar g = 0; g < LAT; g++) begin : g_stage
         logic [STAGE_BLKS:0] w_ch;
         logic [BLK-1:0]      w_bs [STAGE_BLKS];
         logic [WIDTH-1:0]    w_s;

         assign w_ch[0] = w_src_c[g];

         for (genvar j = 0; j < STAGE_BLKS; j++) begin : g_blk
            localparam int BI = g * STAGE_BLKS + j;
            logic [BLK-1:0] w_a;
            logic [BLK-1:0] w_b;
            logic [BLK:0]   w_z;

            assign w_a = w_src_a[g][BI*BLK +: BLK];
            assign w_b = w_src_b[g][BI*BLK +: BLK];

            if (BI == 0) begin : g_ripple
               assign w_z       = {1'b0, w_a} + {1'b0, w_b} + {{BLK{1'b0}}, w_ch[j]};
               assign w_bs[j]   = w_z[BLK-1:0];
               assign w_ch[j+1] = w_z[BLK];
            end else begin : g_incr
               // Zero-carry sum is independent of the incoming carry; the carry only increments it.
               assign w_z       = {1'b0, w_a} + {1'b0, w_b};
               assign w_bs[j]   = w_z[BLK-1:0] + BLK'(w_ch[j]);
               assign w_ch[j+1] = w_z[BLK] | (w_ch[j] & (&w_z[BLK-1:0]));
            end
         end

         always_comb begin
            w_s = w_src_s[g];
            for (int j = 0; j < STAGE_BLKS; j++) begin
               w_s[(g*STAGE_BLKS+j)*BLK +: BLK] = w_bs[j];
            end
         end

         assign w_nx_s[g] = w_s;
         assign w_nx_c[g] = w_ch[STAGE_BLKS];

         if (g < LAT - 1) begin : g_fwd
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  r_a <= '0;
                  r_b <= '0;
               end else if (w_adv) begin
                  r_a <= w_src_a[g];
                  r_b <= w_src_b[g];
               end
            end

            assign w_src_a[g+1] = r_a;
            assign w_src_b[g+1] = r_b;
            assign w_src_s[g+1] = r_s[g];
            assign w_src_c[g+1] = r_c[g];
         end
      end
   endgenerate

   // Carry into the MSB is recovered as a^b^sum at that bit.
   assign w_ovf = w_src_a[LAT-1][WIDTH-1] ^ w_src_b[LAT-1][WIDTH-1]
                ^ w_nx_s[LAT-1][WIDTH-1] ^ w_nx_c[LAT-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LAT; k++) begin
            r_v[k] <= 1'b0;
            r_s[k] <= '0;
            r_c[k] <= 1'b0;
         end
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         r_v[0] <= bus.in_valid;
         for (int k = 1; k < LAT; k++) begin
            r_v[k] <= r_v[k-1];
         end
         for (int k = 0; k < LAT; k++) begin
            r_s[k] <= w_nx_s[k];
            r_c[k] <= w_nx_c[k];
         end
         r_ovf <= w_ovf;
      end
   end

   assign bus.out_valid = r_v[LAT-1];
   assign bus.out_sum   = r_s[LAT-1];
   assign bus.out_cout  = r_c[LAT-1];
   assign bus.out_ovf   = r_ovf;
endmodule

// File: tb/tb_pipelined_carry_increment_adder.sv
// Scoreboard bench for the carry-increment adder: default config plus three parameter variants.
module tb_pipelined_carry_increment_adder;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [65:0] exp_q [$];

   always #5 clk = ~clk;

   pipelined_carry_increment_adder_if #(.WIDTH(32)) bus   ();
   pipelined_carry_increment_adder_if #(.WIDTH(16)) bus16 ();
   pipelined_carry_increment_adder_if #(.WIDTH(64)) bus64 ();
   pipelined_carry_increment_adder_if #(.WIDTH(32)) bus1  ();

   pipelined_carry_increment_adder #(.WIDTH(32), .BLK(4), .STAGE_BLKS(2))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   pipelined_carry_increment_adder #(.WIDTH(16), .BLK(4), .STAGE_BLKS(1))
      dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
   pipelined_carry_increment_adder #(.WIDTH(64), .BLK(8), .STAGE_BLKS(4))
      dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));
   pipelined_carry_increment_adder #(.WIDTH(32), .BLK(4), .STAGE_BLKS(8))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   // Reference: {ovf, cout, sum} from a wide add, valid for widths up to 64.
   function automatic logic [65:0] ref_calc(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input logic sub, input int w);
      logic [64:0] mask, bb, full;
      logic [63:0] s;
      logic        c;
      mask = (65'd1 << w) - 65'd1;
      bb   = sub ? (~{1'b0, b}) & mask : {1'b0, b} & mask;
      c    = sub | cin;
      full = ({1'b0, a} & mask) + bb + {64'd0, c};
      s    = full[63:0] & mask[63:0];
      ref_calc[63:0] = s;
      ref_calc[64]   = full[w];
      ref_calc[65]   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_sum !== 32'h0 || bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b s=%h c=%b o=%b expected all zero",
                  bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] s;
      logic        c;
      logic        o;
   } vec_t;

   task automatic test_directed();
      vec_t tbl [10];
      tbl[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      tbl[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      tbl[3] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
      tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      tbl[6] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      tbl[7] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      tbl[8] = '{32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b0};
      tbl[9] = '{32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h1000_0000, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.out_ready = 1'b1;
         bus.in_valid  = 1'b1;
         bus.in_a      = tbl[i].a;
         bus.in_b      = tbl[i].b;
         bus.in_cin    = tbl[i].cin;
         bus.in_sub    = tbl[i].sub;
         @(negedge clk);
         bus.in_valid = 1'b0;
         for (int e = 1; e <= LAT; e++) begin
            #1;
            checks++;
            if (bus.out_valid !== (e == LAT)) begin
               errors++;
               $display("FAIL dir%0d_latency: edge %0d out_valid=%b expected %b", i, e, bus.out_valid, e == LAT);
            end
            if (e < LAT) @(negedge clk);
         end
         checks++;
         if (bus.out_sum !== tbl[i].s || bus.out_cout !== tbl[i].c || bus.out_ovf !== tbl[i].o) begin
            errors++;
            $display("FAIL dir%0d_result: got s=%h c=%b o=%b expected s=%h c=%b o=%b", i,
                     bus.out_sum, bus.out_cout, bus.out_ovf, tbl[i].s, tbl[i].c, tbl[i].o);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [65:0] e;
      logic [31:0] a, b;
      logic        ci, sb;
      int          nout;
      exp_q.delete();
      nout = 0;
      for (int cyc = 0; cyc < 100 + LAT + 1; cyc++) begin
         @(negedge clk);
         bus.out_ready = 1'b1;
         a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
         bus.in_valid = (cyc < 100);
         bus.in_a = a; bus.in_b = b; bus.in_cin = ci; bus.in_sub = sb;
         #1;
         checks++;
         if (bus.out_valid !== (cyc >= LAT && cyc < 100 + LAT)) begin
            errors++;
            $display("FAIL b2b_valid: cycle %0d out_valid=%b expected %b", cyc, bus.out_valid,
                     (cyc >= LAT && cyc < 100 + LAT));
         end
         if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nout++;
            checks++;
            if ({bus.out_ovf, bus.out_cout, bus.out_sum} !== {e[65], e[64], e[31:0]}) begin
               errors++;
               $display("FAIL b2b_data: got o=%b c=%b s=%h expected o=%b c=%b s=%h",
                        bus.out_ovf, bus.out_cout, bus.out_sum, e[65], e[64], e[31:0]);
            end
         end
         if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_calc({32'd0, a}, {32'd0, b}, ci, sb, 32));
      end
      bus.in_valid = 1'b0;
      checks++;
      if (nout != 100 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_count: got %0d results, %0d pending, expected 100 and 0", nout, exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      logic [65:0] e;
      logic [31:0] a, b, hs;
      logic        ci, sb, hv, hc, ho;
      int          sent, rcvd;
      exp_q.delete();
      sent = 0; rcvd = 0; hv = 1'b0; hs = '0; hc = 1'b0; ho = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (hv) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== hs || bus.out_cout !== hc || bus.out_ovf !== ho) begin
               errors++;
               $display("FAIL bp_stable: got v=%b s=%h c=%b o=%b expected v=1 s=%h c=%b o=%b",
                        bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf, hs, hc, ho);
            end
         end
         a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
         bus.out_ready = (cyc >= 300) ? 1'b1 : 1'($urandom_range(0, 1));
         bus.in_valid  = (cyc < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.in_a = a; bus.in_b = b; bus.in_cin = ci; bus.in_sub = sb;
         #1;
         checks++;
         if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
            errors++;
            $display("FAIL bp_in_ready: got %b expected %b", bus.in_ready, (!bus.out_valid || bus.out_ready));
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL bp_duplicate: got result s=%h expected no pending beat", bus.out_sum);
            end else begin
               e = exp_q.pop_front();
               rcvd++;
               if ({bus.out_ovf, bus.out_cout, bus.out_sum} !== {e[65], e[64], e[31:0]}) begin
                  errors++;
                  $display("FAIL bp_data: got o=%b c=%b s=%h expected o=%b c=%b s=%h",
                           bus.out_ovf, bus.out_cout, bus.out_sum, e[65], e[64], e[31:0]);
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(ref_calc({32'd0, a}, {32'd0, b}, ci, sb, 32));
            sent++;
         end
         hv = bus.out_valid && !bus.out_ready;
         hs = bus.out_sum; hc = bus.out_cout; ho = bus.out_ovf;
      end
      checks++;
      if (rcvd != sent || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_count: got %0d received, %0d pending, expected %0d and 0", rcvd, exp_q.size(), sent);
      end
   endtask

   task automatic test_reset_midflight();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.out_ready = 1'b0;
         bus.in_valid  = 1'b1;
         bus.in_a = $urandom; bus.in_b = $urandom; bus.in_cin = 1'b0; bus.in_sub = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL midrst_before: got out_valid=%b expected 1", bus.out_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_sum !== 32'h0) begin
         errors++;
         $display("FAIL midrst_flush: got out_valid=%b sum=%h expected 0/0", bus.out_valid, bus.out_sum);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stale: cycle %0d out_valid=%b expected 0", c, bus.out_valid);
         end
      end
   endtask

   task automatic test_param_sweep();
      localparam int N = 60;
      logic [65:0] q16 [$];
      logic [65:0] q64 [$];
      logic [65:0] q1  [$];
      logic [65:0] e;
      logic [63:0] a, b;
      logic        ci, sb;
      for (int cyc = 0; cyc < N + 6; cyc++) begin
         @(negedge clk);
         a = {$urandom, $urandom}; b = {$urandom, $urandom};
         ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
         bus16.out_ready = 1'b1; bus64.out_ready = 1'b1; bus1.out_ready = 1'b1;
         bus16.in_valid = (cyc < N); bus64.in_valid = (cyc < N); bus1.in_valid = (cyc < N);
         bus16.in_a = a[15:0]; bus16.in_b = b[15:0]; bus16.in_cin = ci; bus16.in_sub = sb;
         bus64.in_a = a;       bus64.in_b = b;       bus64.in_cin = ci; bus64.in_sub = sb;
         bus1.in_a  = a[31:0]; bus1.in_b  = b[31:0]; bus1.in_cin  = ci; bus1.in_sub  = sb;
         #1;
         checks++;
         if (bus16.out_valid !== (cyc >= 4 && cyc < N + 4) || bus64.out_valid !== (cyc >= 2 && cyc < N + 2)
             || bus1.out_valid !== (cyc >= 1 && cyc < N + 1)) begin
            errors++;
            $display("FAIL sweep_latency: cycle %0d got v16=%b v64=%b v1=%b expected %b %b %b", cyc,
                     bus16.out_valid, bus64.out_valid, bus1.out_valid,
                     (cyc >= 4 && cyc < N + 4), (cyc >= 2 && cyc < N + 2), (cyc >= 1 && cyc < N + 1));
         end
         if (bus16.out_valid && q16.size() > 0) begin
            e = q16.pop_front();
            checks++;
            if ({bus16.out_ovf, bus16.out_cout, bus16.out_sum} !== {e[65], e[64], e[15:0]}) begin
               errors++;
               $display("FAIL sweep16_data: got o=%b c=%b s=%h expected o=%b c=%b s=%h",
                        bus16.out_ovf, bus16.out_cout, bus16.out_sum, e[65], e[64], e[15:0]);
            end
         end
         if (bus64.out_valid && q64.size() > 0) begin
            e = q64.pop_front();
            checks++;
            if ({bus64.out_ovf, bus64.out_cout, bus64.out_sum} !== {e[65], e[64], e[63:0]}) begin
               errors++;
               $display("FAIL sweep64_data: got o=%b c=%b s=%h expected o=%b c=%b s=%h",
                        bus64.out_ovf, bus64.out_cout, bus64.out_sum, e[65], e[64], e[63:0]);
            end
         end
         if (bus1.out_valid && q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            if ({bus1.out_ovf, bus1.out_cout, bus1.out_sum} !== {e[65], e[64], e[31:0]}) begin
               errors++;
               $display("FAIL sweep32x1_data: got o=%b c=%b s=%h expected o=%b c=%b s=%h",
                        bus1.out_ovf, bus1.out_cout, bus1.out_sum, e[65], e[64], e[31:0]);
            end
         end
         if (bus16.in_valid && bus16.in_ready) q16.push_back(ref_calc(a, b, ci, sb, 16));
         if (bus64.in_valid && bus64.in_ready) q64.push_back(ref_calc(a, b, ci, sb, 64));
         if (bus1.in_valid && bus1.in_ready)   q1.push_back(ref_calc(a, b, ci, sb, 32));
      end
      checks++;
      if (q16.size() != 0 || q64.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL sweep_drain: got pending %0d/%0d/%0d expected 0/0/0", q16.size(), q64.size(), q1.size());
      end
   endtask

   initial begin
      rst_n = 1'b1;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0; bus.in_sub = 1'b0; bus.out_ready = 1'b1;
      bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_cin = 1'b0; bus16.in_sub = 1'b0;
      bus16.out_ready = 1'b1;
      bus64.in_valid = 1'b0; bus64.in_a = '0; bus64.in_b = '0; bus64.in_cin = 1'b0; bus64.in_sub = 1'b0;
      bus64.out_ready = 1'b1;
      bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0; bus1.in_sub = 1'b0;
      bus1.out_ready = 1'b1;
      #2;
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      test_param_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
